// File: rtl/seq_divider.sv
// Multi-cycle restoring divider: one quotient bit per clock, results held until the next accepted start.
// Optional two's-complement mode is enabled by defining SEQ_DIVIDER_SIGNED_EN (adds one sign fix-up cycle).
module seq_divider #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [1:0]       dbg_state
);

    // Handshake: start is a request taken only while idle (busy=0); it is accepted at
    // the edge where it is sampled high in IDLE, busy then stays high until done pulses
    // for one cycle with valid quotient/remainder. Starts seen while busy are dropped.

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_FINISH = 2'd2;
`ifdef SEQ_DIVIDER_SIGNED_EN
    localparam logic [1:0] S_FIXUP  = 2'd3;
`endif

    localparam int             CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  CNT_LOAD = CW'(WIDTH);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
    localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] dvsr;
    logic [WIDTH-1:0] dvnd;

    logic [WIDTH-1:0] dividend_mag;
    logic [WIDTH-1:0] divisor_mag;
    logic             divisor_zero;

    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] r_next;
    logic [WIDTH-1:0] q_next;

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic neg_q;
    logic neg_r;

    // The magnitude of the most-negative value still fits in WIDTH unsigned bits.
    assign dividend_mag = dividend[WIDTH-1] ? (~dividend + ONE) : dividend;
    assign divisor_mag  = divisor[WIDTH-1]  ? (~divisor + ONE)  : divisor;
`else
    assign dividend_mag = dividend;
    assign divisor_mag  = divisor;
`endif

    assign divisor_zero = (divisor == '0);

    // Trial subtraction in WIDTH+1 bits; the top bit is the borrow (negative result).
    assign r_shift = {rem_r, q_r[WIDTH-1]};
    assign trial   = r_shift - {1'b0, dvsr};
    assign r_next  = trial[WIDTH] ? r_shift[WIDTH-1:0] : trial[WIDTH-1:0];
    assign q_next  = {q_r[WIDTH-2:0], ~trial[WIDTH]};

    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            rem_r       <= '0;
            q_r         <= '0;
            dvsr        <= '0;
            dvnd        <= '0;
            quotient    <= '0;
            remainder   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        dvnd        <= dividend;
                        dvsr        <= divisor_mag;
                        rem_r       <= '0;
                        q_r         <= dividend_mag;
                        cnt         <= CNT_LOAD;
                        busy        <= 1'b1;
                        div_by_zero <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
                        neg_q       <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        neg_r       <= dividend[WIDTH-1];
`endif
                        state       <= divisor_zero ? S_FINISH : S_RUN;
                    end
                end

                S_RUN: begin
                    rem_r <= r_next;
                    q_r   <= q_next;
                    cnt   <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
`ifdef SEQ_DIVIDER_SIGNED_EN
                        state     <= S_FIXUP;
`else
                        quotient  <= q_next;
                        remainder <= r_next;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
`endif
                    end
                end

                // Divide by zero: all-ones quotient, dividend passed through as remainder.
                S_FINISH: begin
                    quotient    <= '1;
                    remainder   <= dvnd;
                    div_by_zero <= 1'b1;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    state       <= S_IDLE;
                end

`ifdef SEQ_DIVIDER_SIGNED_EN
                // Quotient truncates toward zero; remainder follows the dividend's sign.
                S_FIXUP: begin
                    quotient  <= neg_q ? (~q_r + ONE) : q_r;
                    remainder <= neg_r ? (~rem_r + ONE) : rem_r;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
`endif

                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Directed testbench for seq_divider at WIDTH=4; define SEQ_DIVIDER_SIGNED_EN to exercise the signed build.
module tb_seq_divider;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         busy;
    logic         done;
    logic         div_by_zero;
    logic [1:0]   dbg_state;

    int n_cmp;
    int n_err;

    seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .dbg_state   (dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver: pulse start for one edge, then watch win negedges after acceptance.
    // k=0 is the negedge right after the accepting edge.
    task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input int win,
                           output int lat, output int ndone, output int nbusy,
                           output logic dbz0, output logic [W-1:0] q0);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = -1;
        ndone = 0;
        nbusy = 0;
        dbz0  = div_by_zero;
        q0    = quotient;
        for (int k = 0; k <= win; k++) begin
            if (k > 0) @(negedge clk);
            if (done) begin
                ndone++;
                if (lat < 0) lat = k;
            end
            if (busy) nbusy++;
        end
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        start    = 1'b1;
        dividend = 4'd9;
        divisor  = 4'd2;
        repeat (3) @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (quotient !== 4'd0) begin n_err++; $display("FAIL reset_quotient: got %0d expected 0", quotient); end
        n_cmp++; if (remainder !== 4'd0) begin n_err++; $display("FAIL reset_remainder: got %0d expected 0", remainder); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", done); end
        n_cmp++; if (div_by_zero !== 1'b0) begin n_err++; $display("FAIL reset_dbz: got %b expected 0", div_by_zero); end
        n_cmp++; if (dbg_state !== 2'd0) begin n_err++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
    endtask

`ifndef SEQ_DIVIDER_SIGNED_EN
    task automatic test_basic();
        int lat, ndone, nbusy;
        logic dbz0;
        logic [W-1:0] q0;
        run_div(4'd13, 4'd3, 7, lat, ndone, nbusy, dbz0, q0);
        n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL basic_latency: got %0d expected 4", lat); end
        n_cmp++; if (ndone !== 1) begin n_err++; $display("FAIL basic_done_count: got %0d expected 1", ndone); end
        n_cmp++; if (nbusy !== 4) begin n_err++; $display("FAIL basic_busy_cycles: got %0d expected 4", nbusy); end
        n_cmp++; if (quotient !== 4'd4) begin n_err++; $display("FAIL basic_quotient: got %0d expected 4", quotient); end
        n_cmp++; if (remainder !== 4'd1) begin n_err++; $display("FAIL basic_remainder: got %0d expected 1", remainder); end
        n_cmp++; if (div_by_zero !== 1'b0) begin n_err++; $display("FAIL basic_dbz: got %b expected 0", div_by_zero); end
    endtask

    task automatic test_div_zero();
        int lat, ndone, nbusy;
        logic dbz0;
        logic [W-1:0] q0;
        run_div(4'd7, 4'd0, 5, lat, ndone, nbusy, dbz0, q0);
        n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL dz_latency: got %0d expected 1", lat); end
        n_cmp++; if (ndone !== 1) begin n_err++; $display("FAIL dz_done_count: got %0d expected 1", ndone); end
        n_cmp++; if (quotient !== 4'd15) begin n_err++; $display("FAIL dz_quotient: got %0d expected 15", quotient); end
        n_cmp++; if (remainder !== 4'd7) begin n_err++; $display("FAIL dz_remainder: got %0d expected 7", remainder); end
        n_cmp++; if (div_by_zero !== 1'b1) begin n_err++; $display("FAIL dz_flag: got %b expected 1", div_by_zero); end
        run_div(4'd9, 4'd2, 7, lat, ndone, nbusy, dbz0, q0);
        n_cmp++; if (dbz0 !== 1'b0) begin n_err++; $display("FAIL dz_clear_at_accept: got %b expected 0", dbz0); end
        n_cmp++; if (q0 !== 4'd15) begin n_err++; $display("FAIL dz_quotient_held: got %0d expected 15", q0); end
        n_cmp++; if (quotient !== 4'd4) begin n_err++; $display("FAIL dz_next_quotient: got %0d expected 4", quotient); end
        n_cmp++; if (remainder !== 4'd1) begin n_err++; $display("FAIL dz_next_remainder: got %0d expected 1", remainder); end
    endtask

    task automatic test_boundaries();
        logic [W-1:0] va [4] = '{4'd15, 4'd2, 4'd0, 4'd15};
        logic [W-1:0] vb [4] = '{4'd1, 4'd5, 4'd7, 4'd15};
        logic [W-1:0] vq [4] = '{4'd15, 4'd0, 4'd0, 4'd1};
        logic [W-1:0] vr [4] = '{4'd0, 4'd2, 4'd0, 4'd0};
        int lat, ndone, nbusy;
        logic dbz0;
        logic [W-1:0] q0;
        for (int i = 0; i < 4; i++) begin
            run_div(va[i], vb[i], 6, lat, ndone, nbusy, dbz0, q0);
            n_cmp++;
            if (quotient !== vq[i] || remainder !== vr[i] || lat !== 4) begin
                n_err++;
                $display("FAIL boundary_%0d_%0d: got q=%0d r=%0d lat=%0d expected q=%0d r=%0d lat=4",
                         va[i], vb[i], quotient, remainder, lat, vq[i], vr[i]);
            end
        end
    endtask

    task automatic test_exhaustive();
        int lat, ndone, nbusy, exp_lat;
        logic dbz0, exp_dbz;
        logic [W-1:0] q0, exp_q, exp_r;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                run_div(W'(a), W'(b), 5, lat, ndone, nbusy, dbz0, q0);
                if (b == 0) begin
                    exp_q = 4'd15; exp_r = W'(a); exp_dbz = 1'b1; exp_lat = 1;
                end else begin
                    exp_q = W'(a / b); exp_r = W'(a % b); exp_dbz = 1'b0; exp_lat = 4;
                end
                n_cmp++;
                if (quotient !== exp_q || remainder !== exp_r || div_by_zero !== exp_dbz ||
                    lat !== exp_lat || ndone !== 1) begin
                    n_err++;
                    $display("FAIL exhaustive_%0d_%0d: got q=%0d r=%0d dbz=%b lat=%0d nd=%0d expected q=%0d r=%0d dbz=%b lat=%0d nd=1",
                             a, b, quotient, remainder, div_by_zero, lat, ndone, exp_q, exp_r, exp_dbz, exp_lat);
                end
            end
        end
    endtask

    task automatic test_restart_ignored();
        int lat, ndone;
        @(negedge clk);
        dividend = 4'd13; divisor = 4'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = -1; ndone = 0;
        for (int k = 0; k <= 10; k++) begin
            if (k > 0) @(negedge clk);
            if (k == 1) begin dividend = 4'd6; divisor = 4'd2; start = 1'b1; end
            if (k == 2) start = 1'b0;
            if (done) begin
                ndone++;
                if (lat < 0) lat = k;
            end
        end
        n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL restart_latency: got %0d expected 4", lat); end
        n_cmp++; if (ndone !== 1) begin n_err++; $display("FAIL restart_done_count: got %0d expected 1", ndone); end
        n_cmp++; if (quotient !== 4'd4) begin n_err++; $display("FAIL restart_quotient: got %0d expected 4", quotient); end
        n_cmp++; if (remainder !== 4'd1) begin n_err++; $display("FAIL restart_remainder: got %0d expected 1", remainder); end
    endtask

    task automatic test_reset_mid();
        int ndone, lat, nbusy;
        logic dbz0;
        logic [W-1:0] q0;
        @(negedge clk);
        dividend = 4'd14; divisor = 4'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (quotient !== 4'd0) begin n_err++; $display("FAIL midrst_quotient: got %0d expected 0", quotient); end
        n_cmp++; if (remainder !== 4'd0) begin n_err++; $display("FAIL midrst_remainder: got %0d expected 0", remainder); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        ndone = 0;
        for (int k = 0; k < 6; k++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        n_cmp++; if (ndone !== 0) begin n_err++; $display("FAIL midrst_no_done: got %0d expected 0", ndone); end
        run_div(4'd14, 4'd3, 6, lat, ndone, nbusy, dbz0, q0);
        n_cmp++; if (quotient !== 4'd4) begin n_err++; $display("FAIL midrst_after_quotient: got %0d expected 4", quotient); end
        n_cmp++; if (remainder !== 4'd2) begin n_err++; $display("FAIL midrst_after_remainder: got %0d expected 2", remainder); end
    endtask

    task automatic test_back_to_back();
        int ndone;
        logic [W-1:0] q_first, q_k5;
        logic busy_k5;
        @(negedge clk);
        dividend = 4'd10; divisor = 4'd3; start = 1'b1;
        @(negedge clk);
        ndone = 0; q_first = '0; q_k5 = '0; busy_k5 = 1'b0;
        for (int k = 0; k <= 10; k++) begin
            if (k > 0) @(negedge clk);
            if (k == 1) begin dividend = 4'd11; divisor = 4'd2; end
            if (k == 4) q_first = quotient;
            if (k == 5) begin q_k5 = quotient; busy_k5 = busy; start = 1'b0; end
            if (done) ndone++;
        end
        n_cmp++; if (q_first !== 4'd3) begin n_err++; $display("FAIL b2b_first_quotient: got %0d expected 3", q_first); end
        n_cmp++; if (busy_k5 !== 1'b1) begin n_err++; $display("FAIL b2b_second_busy: got %b expected 1", busy_k5); end
        n_cmp++; if (q_k5 !== 4'd3) begin n_err++; $display("FAIL b2b_quotient_held: got %0d expected 3", q_k5); end
        n_cmp++; if (ndone !== 2) begin n_err++; $display("FAIL b2b_done_count: got %0d expected 2", ndone); end
        n_cmp++; if (quotient !== 4'd5) begin n_err++; $display("FAIL b2b_second_quotient: got %0d expected 5", quotient); end
        n_cmp++; if (remainder !== 4'd1) begin n_err++; $display("FAIL b2b_second_remainder: got %0d expected 1", remainder); end
    endtask
`else
    task automatic test_signed();
        int lat, ndone, nbusy;
        logic dbz0;
        logic [W-1:0] q0;
        // -7 / 2 -> -3 r -1
        run_div(4'b1001, 4'd2, 8, lat, ndone, nbusy, dbz0, q0);
        n_cmp++; if (lat !== 5) begin n_err++; $display("FAIL signed_latency: got %0d expected 5", lat); end
        n_cmp++; if (quotient !== 4'b1101) begin n_err++; $display("FAIL signed_quotient: got %0d expected 13", quotient); end
        n_cmp++; if (remainder !== 4'b1111) begin n_err++; $display("FAIL signed_remainder: got %0d expected 15", remainder); end
        // -8 / -1 -> -8 r 0
        run_div(4'b1000, 4'b1111, 8, lat, ndone, nbusy, dbz0, q0);
        n_cmp++; if (quotient !== 4'b1000) begin n_err++; $display("FAIL signed_ovf_quotient: got %0d expected 8", quotient); end
        n_cmp++; if (remainder !== 4'd0) begin n_err++; $display("FAIL signed_ovf_remainder: got %0d expected 0", remainder); end
        n_cmp++; if (div_by_zero !== 1'b0) begin n_err++; $display("FAIL signed_ovf_dbz: got %b expected 0", div_by_zero); end
        // -3 / 0 -> -1 r -3, flag set, one cycle
        run_div(4'b1101, 4'd0, 5, lat, ndone, nbusy, dbz0, q0);
        n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL signed_dz_latency: got %0d expected 1", lat); end
        n_cmp++; if (quotient !== 4'b1111 || remainder !== 4'b1101 || div_by_zero !== 1'b1) begin
            n_err++;
            $display("FAIL signed_dz_result: got q=%0d r=%0d dbz=%b expected q=15 r=13 dbz=1", quotient, remainder, div_by_zero);
        end
    endtask
`endif

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        test_reset();
`ifndef SEQ_DIVIDER_SIGNED_EN
        test_basic();
        test_div_zero();
        test_boundaries();
        test_restart_ignored();
        test_reset_mid();
        test_back_to_back();
        test_exhaustive();
`else
        test_signed();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
